// File: rtl/remote_cmd_sched_if.sv
// Bundle of the requester-side and transceiver-side signals of the remote command scheduler.
// The master modport is the scheduler's view; slave is the view of the logic around it.
interface remote_cmd_sched_if;
  logic [1:0]  req;
  logic [7:0]  cmd0;
  logic [7:0]  cmd1;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [1:0]  done;
  logic [1:0]  status;
  logic [7:0]  resp_out;
  logic        busy;
  logic        rc_send_cmd;
  logic [7:0]  rc_cmd;
  logic [15:0] rc_data;
  logic        rc_cmd_sent;
  logic        rc_resp_rdy;
  logic [7:0]  rc_resp;
  logic        rc_clr_resp_rdy;

  modport master (
    input  req, cmd0, cmd1, data0, data1, rc_cmd_sent, rc_resp_rdy, rc_resp,
    output done, status, resp_out, busy, rc_send_cmd, rc_cmd, rc_data, rc_clr_resp_rdy
  );

  modport slave (
    output req, cmd0, cmd1, data0, data1, rc_cmd_sent, rc_resp_rdy, rc_resp,
    input  done, status, resp_out, busy, rc_send_cmd, rc_cmd, rc_data, rc_clr_resp_rdy
  );
endinterface

// File: rtl/remote_cmd_sched.sv
// Shares one remote command link between two requesters: round-robin grant, frame launch,
// response wait with timeout and bounded relaunch, and ACK/NAK/TIMEOUT report to the winner.
module remote_cmd_sched #(
  parameter logic [7:0]  ACK_VAL     = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 2_000_000,
  parameter int unsigned MAX_RETRY   = 2
) (
  input logic                clk,
  input logic                rst_n,
  remote_cmd_sched_if.master bus
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYC - 1);
  localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRY);

  localparam logic [1:0] StatAck     = 2'b00;
  localparam logic [1:0] StatNak     = 2'b01;
  localparam logic [1:0] StatTimeout = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWaitSent,
    StWaitResp,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic                id_q, id_d;       // granted requester
  logic                last_q, last_d;   // requester served most recently
  logic [7:0]          cmd_q, cmd_d;
  logic [15:0]         data_q, data_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [1:0]          status_q, status_d;
  logic [7:0]          resp_q, resp_d;
  logic                clr_q, clr_d;     // response consumed, clear it during DONE

  logic timeout;
  logic win;

  assign timeout = (timer_q == TimeoutLast);
  // On a tie the requester not served last wins.
  assign win     = bus.req[1] & (~bus.req[0] | ~last_q);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
      cmd_q    <= '0;
      data_q   <= '0;
      retry_q  <= '0;
      timer_q  <= '0;
      status_q <= '0;
      resp_q   <= '0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      last_q   <= last_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      retry_q  <= retry_d;
      timer_q  <= timer_d;
      status_q <= status_d;
      resp_q   <= resp_d;
      clr_q    <= clr_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    last_d   = last_q;
    cmd_d    = cmd_q;
    data_d   = data_q;
    retry_d  = retry_q;
    timer_d  = timer_q;
    status_d = status_q;
    resp_d   = resp_q;
    clr_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          id_d    = win;
          cmd_d   = win ? bus.cmd1 : bus.cmd0;
          data_d  = win ? bus.data1 : bus.data0;
          retry_d = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        timer_d = '0;
        state_d = StWaitSent;
      end
      StWaitSent: begin
        timer_d = timer_q + TimerW'(1);
        // The sent pulse takes priority over a coincident timeout.
        if (bus.rc_cmd_sent) begin
          state_d = StWaitResp;
        end else if (timeout) begin
          if (retry_q < RetryMax) begin
            retry_d = retry_q + RetryW'(1);
            state_d = StSend;
          end else begin
            status_d = StatTimeout;
            resp_d   = '0;
            state_d  = StDone;
          end
        end
      end
      StWaitResp: begin
        timer_d = timer_q + TimerW'(1);
        // A response on the timeout cycle is still accepted.
        if (bus.rc_resp_rdy) begin
          resp_d   = bus.rc_resp;
          status_d = (bus.rc_resp == ACK_VAL) ? StatAck : StatNak;
          clr_d    = 1'b1;
          state_d  = StDone;
        end else if (timeout) begin
          if (retry_q < RetryMax) begin
            retry_d = retry_q + RetryW'(1);
            state_d = StSend;
          end else begin
            status_d = StatTimeout;
            resp_d   = '0;
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        last_d  = id_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state.
  always_comb begin
    bus.done            = 2'b00;
    bus.rc_send_cmd     = (state_q == StSend);
    // SEND flushes any stale response; clr_q acknowledges the consumed one.
    bus.rc_clr_resp_rdy = (state_q == StSend) | clr_q;
    bus.busy            = (state_q != StIdle);
    bus.status          = status_q;
    bus.resp_out        = resp_q;
    bus.rc_cmd          = cmd_q;
    bus.rc_data         = data_q;
    if (state_q == StDone) begin
      bus.done = id_q ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: tb/tb_remote_cmd_sched.sv
// Scoreboard bench for remote_cmd_sched with a behavioural transceiver model.
module tb_remote_cmd_sched;

  localparam int unsigned Timeout = 200;
  localparam int unsigned Retry   = 2;
  localparam int          MaxWait = 3000;

  typedef struct {
    logic [1:0]  done;
    logic [1:0]  status;
    logic [7:0]  resp;
    logic [7:0]  cmd;
    logic [15:0] data;
    int          launches;
    int          gap;
  } exp_t;

  logic clk;
  logic rst_n;

  remote_cmd_sched_if bus ();

  remote_cmd_sched #(
    .ACK_VAL    (8'hA5),
    .TIMEOUT_CYC(Timeout),
    .MAX_RETRY  (Retry)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  // Transceiver model configuration, set by the stimulus before each request.
  int         cfg_sent_delay   = 2;
  int         cfg_resp_delay   = 4;
  int         cfg_resp_attempt = 1;   // 0: never answer
  logic [7:0] cfg_resp_byte    = 8'hA5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] d, input logic [1:0] st, input logic [7:0] rsp,
                      input logic [7:0] c, input logic [15:0] dt, input int l, input int g);
    exp_t e;
    e.done = d; e.status = st; e.resp = rsp; e.cmd = c; e.data = dt;
    e.launches = l; e.gap = g;
    sb_q.push_back(e);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.done == 2'b00 && n < MaxWait);
    if (bus.done == 2'b00) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_wait: no done within %0d cycles, required a done pulse", MaxWait);
    end
  endtask

  // Transceiver model: sent pulse after a delay, then optionally a response level.
  initial begin
    int sent_tmr;
    int resp_tmr;
    int attempt;
    sent_tmr = 0; resp_tmr = 0; attempt = 0;
    bus.rc_cmd_sent = 1'b0;
    bus.rc_resp_rdy = 1'b0;
    bus.rc_resp     = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sent_tmr = 0; resp_tmr = 0; attempt = 0;
        bus.rc_cmd_sent = 1'b0;
        bus.rc_resp_rdy = 1'b0;
        continue;
      end
      bus.rc_cmd_sent = 1'b0;
      if (bus.rc_clr_resp_rdy) bus.rc_resp_rdy = 1'b0;
      if (bus.done != 2'b00) attempt = 0;
      if (resp_tmr > 0) begin
        resp_tmr--;
        if (resp_tmr == 0) begin
          bus.rc_resp_rdy = 1'b1;
          bus.rc_resp     = cfg_resp_byte;
        end
      end
      if (bus.rc_send_cmd) begin
        attempt++;
        sent_tmr = cfg_sent_delay;
        resp_tmr = 0;
      end else if (sent_tmr > 0) begin
        sent_tmr--;
        if (sent_tmr == 0) begin
          bus.rc_cmd_sent = 1'b1;
          if (attempt == cfg_resp_attempt) resp_tmr = cfg_resp_delay;
        end
      end
    end
  end

  // Monitor: counts launches, measures spacing, checks each done against the scoreboard.
  initial begin
    int         cyc;
    int         launches;
    int         last_launch;
    int         gmin;
    int         gmax;
    logic [7:0] l_cmd;
    logic [15:0] l_data;
    exp_t       e;
    cyc = 0; launches = 0; last_launch = 0; gmin = 32'h7fff_ffff; gmax = 0;
    l_cmd = '0; l_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        launches = 0; gmin = 32'h7fff_ffff; gmax = 0;
        continue;
      end
      if (bus.rc_send_cmd) begin
        if (launches > 0) begin
          if (cyc - last_launch < gmin) gmin = cyc - last_launch;
          if (cyc - last_launch > gmax) gmax = cyc - last_launch;
        end
        last_launch = cyc;
        launches++;
        l_cmd  = bus.rc_cmd;
        l_data = bus.rc_data;
      end
      if (bus.done != 2'b00) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'h0);
        end else begin
          e = sb_q.pop_front();
          check("done", 32'(bus.done), 32'(e.done));
          check("status", 32'(bus.status), 32'(e.status));
          check("resp_out", 32'(bus.resp_out), 32'(e.resp));
          check("launch_cmd", 32'(l_cmd), 32'(e.cmd));
          check("launch_data", 32'(l_data), 32'(e.data));
          check("done_cmd", 32'(bus.rc_cmd), 32'(e.cmd));
          check("launches", 32'(launches), 32'(e.launches));
          if (e.gap != 0) begin
            check("gap_min", 32'(gmin), 32'(e.gap));
            check("gap_max", 32'(gmax), 32'(e.gap));
          end
        end
        launches = 0; gmin = 32'h7fff_ffff; gmax = 0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check({tag, "_done"}, 32'(bus.done), 32'h0);
    check({tag, "_status"}, 32'(bus.status), 32'h0);
    check({tag, "_resp_out"}, 32'(bus.resp_out), 32'h0);
    check({tag, "_send"}, 32'(bus.rc_send_cmd), 32'h0);
    check({tag, "_clr"}, 32'(bus.rc_clr_resp_rdy), 32'h0);
    check({tag, "_rc_cmd"}, 32'(bus.rc_cmd), 32'h0);
    check({tag, "_rc_data"}, 32'(bus.rc_data), 32'h0);
  endtask

  // Directed stimulus.
  initial begin
    int n;
    rst_n = 1'b0;
    bus.req = 2'b00;
    bus.cmd0 = 8'h00; bus.cmd1 = 8'h00;
    bus.data0 = 16'h0000; bus.data1 = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Tie out of reset, held for four services: 0,1,0,1.
    bus.cmd0 = 8'h11; bus.data0 = 16'hAAAA;
    bus.cmd1 = 8'h22; bus.data1 = 16'hBBBB;
    for (int i = 0; i < 2; i++) begin
      push(2'b01, 2'b00, 8'hA5, 8'h11, 16'hAAAA, 1, 0);
      push(2'b10, 2'b00, 8'hA5, 8'h22, 16'hBBBB, 1, 0);
    end
    bus.req = 2'b11;
    for (int i = 0; i < 4; i++) wait_done();
    bus.req = 2'b00;
    repeat (3) @(negedge clk);

    // Single request, ACK.
    bus.cmd0 = 8'h02; bus.data0 = 16'h1234;
    push(2'b01, 2'b00, 8'hA5, 8'h02, 16'h1234, 1, 0);
    bus.req = 2'b01;
    wait_done();
    bus.req = 2'b00;
    repeat (3) @(negedge clk);

    // NAK from requester 1: no relaunch.
    cfg_resp_byte = 8'h5A;
    bus.cmd1 = 8'h33; bus.data1 = 16'h5678;
    push(2'b10, 2'b01, 8'h5A, 8'h33, 16'h5678, 1, 0);
    bus.req = 2'b10;
    wait_done();
    bus.req = 2'b00;
    repeat (3) @(negedge clk);

    // First attempt times out, second answered.
    cfg_resp_byte = 8'hA5;
    cfg_resp_attempt = 2;
    bus.cmd1 = 8'h55; bus.data1 = 16'h0F0F;
    push(2'b10, 2'b00, 8'hA5, 8'h55, 16'h0F0F, 2, 201);
    bus.req = 2'b10;
    wait_done();
    bus.req = 2'b00;
    repeat (3) @(negedge clk);

    // Response lands on the exact timeout cycle (3 + 197 = 200 after SEND).
    cfg_resp_attempt = 1;
    cfg_sent_delay = 3;
    cfg_resp_delay = 197;
    bus.cmd0 = 8'h66; bus.data0 = 16'h1357;
    push(2'b01, 2'b00, 8'hA5, 8'h66, 16'h1357, 1, 0);
    bus.req = 2'b01;
    wait_done();
    bus.req = 2'b00;
    repeat (3) @(negedge clk);

    // No response at all: three launches 201 cycles apart, then TIMEOUT.
    cfg_sent_delay = 2;
    cfg_resp_delay = 4;
    cfg_resp_attempt = 0;
    bus.cmd0 = 8'h44; bus.data0 = 16'h9ABC;
    push(2'b01, 2'b10, 8'h00, 8'h44, 16'h9ABC, 3, 201);
    bus.req = 2'b01;
    wait_done();
    bus.req = 2'b00;
    repeat (3) @(negedge clk);

    // Reset while waiting for a response: no done for the aborted transaction.
    bus.cmd1 = 8'h77; bus.data1 = 16'h1111;
    bus.req = 2'b10;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rc_send_cmd && n < 20);
    check("abort_launch_seen", 32'(bus.rc_send_cmd), 32'h1);
    repeat (10) @(negedge clk);
    check("abort_busy_before", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    bus.req = 2'b00;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal service after reset.
    cfg_resp_attempt = 1;
    bus.cmd0 = 8'h88; bus.data0 = 16'h2468;
    push(2'b01, 2'b00, 8'hA5, 8'h88, 16'h2468, 1, 0);
    bus.req = 2'b01;
    wait_done();
    bus.req = 2'b00;
    repeat (5) @(negedge clk);

    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
